// File: rtl/vc_multichan_queue.sv
// vc_multichan_queue: shared-storage multi-channel FIFO with round-robin dequeue
module vc_multichan_queue #(
    parameter logic [3:0] p_type         = 4'b0000,
    parameter int         p_msg_nbits    = 8,
    parameter int         p_num_chans    = 4,
    parameter int         p_num_msgs     = 4,
    parameter int         p_afull_thresh = 1,
    localparam int        c_chan_nbits   = $clog2(p_num_chans),
    localparam int        c_addr_nbits   = $clog2(p_num_msgs)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enq_val,
    input  logic [c_chan_nbits-1:0]                 enq_chan,
    output logic                                    enq_rdy,
    input  logic [p_msg_nbits-1:0]                  enq_msg,
    output logic                                    deq_val,
    input  logic                                    deq_rdy,
    output logic [p_msg_nbits-1:0]                  deq_msg,
    output logic [c_chan_nbits-1:0]                 deq_chan,
    output logic [p_num_chans-1:0]                  chan_full,
    output logic [p_num_chans-1:0]                  chan_afull,
    output logic [p_num_chans*(c_addr_nbits+1)-1:0] num_free_entries
);
    localparam int   c_fw     = c_addr_nbits + 1;
    localparam logic c_pipe   = p_type[0];
    localparam logic c_bypass = p_type[1];

    logic [p_msg_nbits-1:0]  rf_q      [p_num_chans*p_num_msgs];
    logic [c_addr_nbits-1:0] enq_ptr_q [p_num_chans];
    logic [c_addr_nbits-1:0] enq_ptr_d [p_num_chans];
    logic [c_addr_nbits-1:0] deq_ptr_q [p_num_chans];
    logic [c_addr_nbits-1:0] deq_ptr_d [p_num_chans];
    logic [c_fw-1:0]         free      [p_num_chans];
    logic [p_num_chans-1:0]  full_q, full_d, empty, enq_hit, deq_hit;
    logic [c_chan_nbits-1:0] rr_q, rr_d, grant;
    logic                    found, chan_legal, byp, byp_taken, do_enq, do_deq, write_en;

    // Per-channel occupancy status derived from pointers and full bits
    always_comb begin
        for (int c = 0; c < p_num_chans; c++) begin
            empty[c] = ~full_q[c] & (enq_ptr_q[c] == deq_ptr_q[c]);
            free[c] = full_q[c] ? '0 : c_fw'(p_num_msgs) - {1'b0, enq_ptr_q[c] - deq_ptr_q[c]};
            num_free_entries[c*c_fw +: c_fw] = free[c];
            chan_afull[c] = int'(free[c]) <= p_afull_thresh;
        end
        chan_full = full_q;
    end

    // Round-robin grant: first non-empty channel at or after rr_q, wrapping
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < p_num_chans; i++) begin
            if (!found && !empty[(int'(rr_q) + i) % p_num_chans]) begin
                found = 1'b1;
                grant = c_chan_nbits'((int'(rr_q) + i) % p_num_chans);
            end
        end
    end

    // Handshake, bypass and pipe-mode ready logic
    always_comb begin
        chan_legal = int'(enq_chan) < p_num_chans;
        byp        = c_bypass & (&empty) & enq_val & chan_legal;
        deq_val    = byp | found;
        deq_chan   = byp ? enq_chan : grant;
        deq_msg    = byp ? enq_msg : rf_q[{grant, deq_ptr_q[grant]}];
        do_deq     = deq_val & deq_rdy;
        byp_taken  = byp & deq_rdy;
        enq_rdy    = chan_legal & (~full_q[enq_chan] | (c_pipe & do_deq & (deq_chan == enq_chan)));
        do_enq     = enq_val & enq_rdy;
        write_en   = do_enq & ~byp_taken;
    end

    // Next-state pointers, full bits and round-robin pointer
    always_comb begin
        rr_d = byp_taken ? c_chan_nbits'((int'(enq_chan) + 1) % p_num_chans)
             : do_deq    ? c_chan_nbits'((int'(grant) + 1) % p_num_chans)
             : rr_q;
        for (int c = 0; c < p_num_chans; c++) begin
            enq_hit[c]   = write_en & (int'(enq_chan) == c);
            deq_hit[c]   = do_deq & ~byp_taken & (int'(grant) == c);
            enq_ptr_d[c] = enq_ptr_q[c] + c_addr_nbits'(enq_hit[c]);
            deq_ptr_d[c] = deq_ptr_q[c] + c_addr_nbits'(deq_hit[c]);
            full_d[c]    = (enq_hit[c] & ~deq_hit[c] & (enq_ptr_d[c] == deq_ptr_q[c])) ? 1'b1
                         : (deq_hit[c] & ~enq_hit[c]) ? 1'b0
                         : full_q[c];
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q      <= '0;
            full_q    <= '0;
            enq_ptr_q <= '{default: '0};
            deq_ptr_q <= '{default: '0};
        end else begin
            rr_q      <= rr_d;
            full_q    <= full_d;
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
        end
    end

    // Shared regfile write port, addressed {chan, ptr}
    always_ff @(posedge clk) begin
        if (reset && write_en) rf_q[{enq_chan, enq_ptr_q[enq_chan]}] <= enq_msg;
    end

    // Handshake signals must be known whenever out of reset
    always_ff @(posedge clk) begin
        if (reset) assert (!$isunknown({enq_val, deq_rdy, enq_rdy, deq_val}));
    end
endmodule

// File: doc/vc_multichan_queue.md
Name: vc_multichan_queue

Overview:
- Shared-storage, multi-channel message queue: one enqueue port tagged with a channel ID, one dequeue port.
- Each of p_num_chans channels is an independent FIFO of p_num_msgs entries.
- Dequeue selects among non-empty channels with a round-robin arbiter.
- Used as the virtual-channel input buffer in front of network/memory ports. Channel ordering is preserved; there is no ordering between channels.

Parameters:
- p_type, 4'b0000, queue mode: 4'b0000 normal, 4'b0001 pipe, 4'b0010 bypass; bits combine as in the existing queue defines.
- p_msg_nbits, 8, message width in bits.
- p_num_chans, 4, number of channels; must be ≥2.
- p_num_msgs, 4, entries per channel; must be a power of two and ≥2.
- p_afull_thresh, 1, a channel is almost-full when its free entries ≤ this value.
- c_chan_nbits, $clog2(p_num_chans), derived; not set from outside.
- c_addr_nbits, $clog2(p_num_msgs), derived; not set from outside.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset; 0 at a posedge clears all state.
- enq_val  in  1  enqueue message valid.
- enq_chan  in  c_chan_nbits  target channel of the enqueue.
- enq_rdy  out  1  target channel can accept this cycle.
- enq_msg  in  p_msg_nbits  enqueue payload.
- deq_val  out  1  dequeue message valid.
- deq_rdy  in  1  consumer ready.
- deq_msg  out  p_msg_nbits  dequeue payload.
- deq_chan  out  c_chan_nbits  channel of deq_msg.
- chan_full  out  p_num_chans  bit i set when channel i holds p_num_msgs entries.
- chan_afull  out  p_num_chans  bit i set when free(i) ≤ p_afull_thresh.
- num_free_entries  out  p_num_chans*(c_addr_nbits+1)  free count per channel; channel i occupies bits [(i+1)*(c_addr_nbits+1)-1 : i*(c_addr_nbits+1)].

Behaviour:
- Storage and per-channel state:
  - Storage is one 1r1w regfile of p_num_chans*p_num_msgs entries, addressed {chan, ptr}.
  - Each channel has an enq_ptr, a deq_ptr and a full bit.
  - Pointers wrap naturally modulo p_num_msgs.
- Reset (reset==0 at posedge):
  - All pointers, full bits and the round-robin pointer go to 0. Stored contents are discarded.
  - After reset: deq_val=0 (bypass mode: deq_val follows enq_val), chan_full=0, every num_free_entries field = p_num_msgs, chan_afull(i) = (p_num_msgs ≤ p_afull_thresh).
  - Reset mid-traffic drops all queued messages; no handshake completes in the reset cycle.
- Handshakes:
  - do_enq = enq_val & enq_rdy; do_deq = deq_val & deq_rdy.
  - Payload and channel must remain stable while val is high and rdy is low.
- enq_rdy:
  - Normally ~full[enq_chan].
  - If enq_chan ≥ p_num_chans, enq_rdy=0.
  - Pipe mode: enq_rdy is additionally 1 when full[enq_chan] & do_deq & deq_chan==enq_chan. This is a combinational deq_rdy→enq_rdy path.
- Dequeue arbitration:
  - Eligible set = channels with ≥1 entry.
  - Grant is the first eligible channel at or after rr_ptr, scanning upward with wrap.
  - deq_val = |eligible; deq_chan = granted channel; deq_msg = regfile[{grant, deq_ptr[grant]}] (combinational read).
  - On do_deq, rr_ptr <= grant+1 (mod p_num_chans). Otherwise rr_ptr holds, so the grant stays stable while the consumer stalls.
- Bypass mode:
  - Applies when every channel is empty and enq_val=1 with a legal channel.
  - Then deq_val=1, deq_msg=enq_msg, deq_chan=enq_chan.
  - If deq_rdy=1, nothing is written, pointers hold, and rr_ptr <= enq_chan+1.
  - If deq_rdy=0, the message is written normally.
- Writes: write_en = do_enq & ~bypass_taken; writes location {enq_chan, enq_ptr[enq_chan]} and increments that enq_ptr.
- Full-bit updates:
  - Simultaneous enq and deq on the same channel: count unchanged, both pointers advance.
  - Same channel when full: legal only in pipe mode; full stays 1.
  - Different channels: both update independently.
  - full[c] is set when an enq alone on c makes enq_ptr_inc==deq_ptr. It is cleared by any deq on c without a concurrent enq on c.
- Free count: free(c) = full ? 0 : p_num_msgs - (enq_ptr - deq_ptr mod p_num_msgs). Combinational from state.
- Assertions (when reset==1): enq_val, deq_rdy, enq_rdy and deq_val are not X.
- Line trace format: enq val/rdy/msg, then per-channel occupancy, then deq val/rdy/chan:msg.

Test Plan:
1. Defaults; reset=0 for 2 cycles, then 1 → deq_val=0, chan_full=0000, every free field=4, chan_afull=0000.
2. Enq 0xA1,0xA2,0xA3 to ch2 with deq_rdy=0 → free(2)=1, chan_afull=0100. Enq 0xA4 → chan_full=0100, enq_rdy=0 for ch2; enq to ch0 still accepted.
3. One message queued in each of ch0..ch3, deq_rdy=1 every cycle → deq_chan sequence 0,1,2,3. Refill, rr_ptr=0 → same order. Hold deq_rdy=0 with ch1,ch3 non-empty and rr_ptr=2 → deq_chan=3 stable until accepted.
4. Normal mode, ch1 full, deq grants ch1, enq to ch1 with deq_rdy=1 → enq_rdy=0. Pipe mode, same stimulus → enq_rdy=1, occupancy stays 4, FIFO order preserved across pointer wrap (8 enq/deq pairs of 0x10..0x17 dequeued in order).
5. Bypass mode, all empty, enq ch3 msg 0x5C, deq_rdy=1 → same cycle deq_val=1, deq_chan=3, deq_msg=0x5C; next cycle free(3)=4, rr_ptr=0. With deq_rdy=0 instead → free(3)=3.
6. ch0 holding 3 entries, reset=0 for one cycle while enq_val=deq_rdy=1 → next cycle free(0)=4, deq_val=0, no message emitted.
